hazard_ctrl: RTL and testbench

- Pipeline hazard and stall controller for the 5-stage MIPS core.
- Sequences the PC, the IF/ID register and the ID/EX pipeline register.
- Detects load-use hazards, squashes instructions on taken branches, and holds the front end while a multi-cycle multiply occupies EX.
- Drives the PC write enable, IF/ID write/flush, and the ID/EX bubble select (the control-field mux in front of the ID/EX register).

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/load_use_detect.sv | 19 +
 rtl/hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_hazard_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM state type,
// ID/EX bubble field values and the MemRead position inside the M field.
package pipe_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] WB_BUBBLE = 2'b01;
  localparam logic [1:0] M_BUBBLE  = 2'b00;
  localparam logic [3:0] EX_BUBBLE = 4'b0000;

  // M field is {MemRead, MemWrite}
  localparam int M_MEMREAD_BIT = 1;

  function automatic logic [3:0] mul_cnt_init(input int latency);
    return 4'(latency - 2);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds a source of
// the instruction in ID. Register zero never creates a dependency.
module load_use_detect (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       load_use
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (ex_rt == id_rs);
  assign rt_match = id_uses_rt && (ex_rt == id_rt);
  assign load_use = ex_mem_read && (ex_rt != 5'd0) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use stall, branch squash, multiply hold.
// Optional stall counter on stall_cycles is built when HAZARD_PERF_CNT_EN is defined.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   RUN      | normal flow; branch squash, load-use stall, multiply issue
//   MUL_WAIT | multiply occupies EX; front end held, bubbles into ID/EX
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_mul,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             mul_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles
`endif
);

  if (MUL_LATENCY < 2 || MUL_LATENCY > 16 || CNT_W < 1) begin : g_bad_param
    $error("hazard_ctrl: MUL_LATENCY must be 2..16 and CNT_W >= 1");
  end

  localparam logic [3:0] MUL_CNT_INIT = mul_cnt_init(MUL_LATENCY);

  state_t     state;
  logic [3:0] cnt;
  logic       load_use;

  load_use_detect u_load_use_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .load_use    (load_use)
  );

  // Multiply issues only when nothing of higher priority claims the cycle
  logic mul_issue;
  assign mul_issue = (state == RUN) && !branch_taken && !load_use && id_is_mul;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      case (state)
        RUN: begin
          if (mul_issue) begin
            state <= MUL_WAIT;
            cnt   <= MUL_CNT_INIT;
          end
        end
        MUL_WAIT: begin
          if (cnt == 4'd0) state <= RUN;
          else             cnt   <= cnt - 4'd1;
        end
        default: begin
          state <= RUN;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    mul_busy    = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (state == MUL_WAIT) begin
      // branch_taken cannot legally arrive here and is deliberately ignored
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      mul_busy    = 1'b1;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] perf_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cnt <= '0;
    end else if (!pc_write && (perf_cnt != {CNT_W{1'b1}})) begin
      perf_cnt <= perf_cnt + CNT_W'(1);
    end
  end

  assign stall_cycles = perf_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MUL_LATENCY=4). Stall counter checks are
// included when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       id_is_mul;
  logic       ex_mem_read;
  logic [4:0] ex_rt;
  logic       branch_taken;
  logic       pc_write;
  logic       ifid_write;
  logic       ifid_flush;
  logic       idex_bubble;
  logic       mul_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cycles;
`endif

  int n_vec = 0;
  int n_bad = 0;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, mul_busy}
  logic [4:0] obs;
  assign obs = {pc_write, ifid_write, ifid_flush, idex_bubble, mul_busy};

  localparam logic [4:0] O_RUN  = 5'b11000;
  localparam logic [4:0] O_LU   = 5'b00010;
  localparam logic [4:0] O_BR   = 5'b11110;
  localparam logic [4:0] O_MULW = 5'b00011;
  localparam logic [4:0] O_RST  = 5'b00110;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses;
    logic       mul;
    logic       mr;
    logic [4:0] ert;
    logic       br;
    logic [4:0] exp;
  } vec_t;

  hazard_ctrl #(.MUL_LATENCY(4), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .id_is_mul    (id_is_mul),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .branch_taken (branch_taken),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .mul_busy     (mul_busy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && mul_busy && branch_taken)
      $error("assertion: branch_taken asserted while multiply occupies EX");
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got t=%0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input vec_t v);
    id_rs        = v.rs;
    id_rt        = v.rt;
    id_uses_rt   = v.uses;
    id_is_mul    = v.mul;
    ex_mem_read  = v.mr;
    ex_rt        = v.ert;
    branch_taken = v.br;
  endtask

  task automatic drive_idle();
    vec_t v;
    v = '{5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, O_RUN};
    drive(v);
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if (obs !== O_RST) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b, expected %b", obs, O_RST);
    end
`ifdef HAZARD_PERF_CNT_EN
    n_vec++;
    if (stall_cycles !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_stall_cycles: got %0d, expected 0", stall_cycles);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    #1;
    n_vec++;
    if (obs !== O_RUN) begin
      n_bad++;
      $display("FAIL reset_release_idle: got %b, expected %b", obs, O_RUN);
    end
  endtask

  task automatic test_load_use();
    vec_t t [8];
    t = '{
      '{5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, O_LU},
      '{5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0, O_RUN},
      '{5'd3, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, O_LU},
      '{5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0, O_RUN},
      '{5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, O_RUN},
      '{5'd6, 5'd5, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, O_RUN},
      '{5'd6, 5'd5, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, O_RUN},
      '{5'd5, 5'd9, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, O_LU}
    };
    foreach (t[i]) begin
      @(negedge clk);
      drive(t[i]);
      #1;
      n_vec++;
      if (obs !== t[i].exp) begin
        n_bad++;
        $display("FAIL load_use[%0d]: got %b, expected %b", i, obs, t[i].exp);
      end
    end
  endtask

  task automatic test_branch();
    vec_t t [5];
    t = '{
      '{5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, O_BR},
      '{5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0, O_RUN},
      '{5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, O_BR},
      '{5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, O_RUN},
      '{5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1, O_BR}
    };
    foreach (t[i]) begin
      @(negedge clk);
      drive(t[i]);
      #1;
      n_vec++;
      if (obs !== t[i].exp) begin
        n_bad++;
        $display("FAIL branch[%0d]: got %b, expected %b", i, obs, t[i].exp);
      end
    end
  endtask

  task automatic test_mul();
    vec_t t [6];
    t = '{
      '{5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, O_RUN},
      '{5'd4, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b0, O_MULW},
      '{5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, O_MULW},
      '{5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, O_MULW},
      '{5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, O_RUN},
      '{5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, O_RUN}
    };
    foreach (t[i]) begin
      @(negedge clk);
      drive(t[i]);
      #1;
      n_vec++;
      if (obs !== t[i].exp) begin
        n_bad++;
        $display("FAIL mul[%0d]: got %b, expected %b", i, obs, t[i].exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t m;
    logic [4:0] exp_seq [7];
    m = '{5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, O_RUN};
    exp_seq = '{O_RUN, O_MULW, O_MULW, O_MULW, O_RUN, O_MULW, O_MULW};
    foreach (exp_seq[i]) begin
      @(negedge clk);
      drive(m);
      #1;
      n_vec++;
      if (obs !== exp_seq[i]) begin
        n_bad++;
        $display("FAIL back_to_back[%0d]: got %b, expected %b", i, obs, exp_seq[i]);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_vec++;
    if (obs !== O_RST) begin
      n_bad++;
      $display("FAIL b2b_reset_immediate: got %b, expected %b", obs, O_RST);
    end
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    #1;
    n_vec++;
    if (obs !== O_RUN) begin
      n_bad++;
      $display("FAIL b2b_reset_to_run: got %b, expected %b", obs, O_RUN);
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_cnt();
    vec_t t [7];
    vec_t lu;
    t = '{
      '{5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, O_LU},
      '{5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, O_RUN},
      '{5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, O_RUN},
      '{5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, O_MULW},
      '{5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, O_MULW},
      '{5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, O_MULW},
      '{5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, O_RUN}
    };
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_vec++;
    if (stall_cycles !== 16'd0) begin
      n_bad++;
      $display("FAIL perf_reset_clear: got %0d, expected 0", stall_cycles);
    end
    @(negedge clk);
    reset = 1'b0;
    foreach (t[i]) begin
      @(negedge clk);
      drive(t[i]);
      #1;
    end
    n_vec++;
    if (stall_cycles !== 16'd4) begin
      n_bad++;
      $display("FAIL perf_count: got %0d, expected 4", stall_cycles);
    end
    lu = '{5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, O_LU};
    @(negedge clk);
    drive(lu);
    force dut.perf_cnt = 16'hFFFE;
    #1;
    release dut.perf_cnt;
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if (stall_cycles !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL perf_saturate: got %h, expected ffff", stall_cycles);
    end
    drive_idle();
  endtask
`endif

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_load_use();
    test_branch();
    test_mul();
    test_back_to_back();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_cnt();
`endif
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
